// File: rtl/cpu_pipe_ctrl.sv
// cpu_pipe_ctrl: scoreboard issue control between fetch and decode, with
// jump/branch wait, flush after taken jumps, error flags and a stall counter.
module cpu_pipe_ctrl #(
  parameter int JB_TIMEOUT = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [3:0]       if_rs1,
  input  logic [3:0]       if_rs2,
  input  logic             if_rs1_used,
  input  logic             if_rs2_used,
  input  logic [3:0]       if_rd,
  input  logic             if_rd_wr,
  input  logic             if_is_jb,
  input  logic             wb_wrt_en,
  input  logic [3:0]       wb_wrt_reg,
  input  logic             mem_busy,
  input  logic             jb_resolve,
  input  logic             jb_taken,
  output logic             issue,
  output logic             pc_en,
  output logic             dec_bubble,
  output logic             flush_if,
  output logic [15:0]      pending,
  output logic             jb_err,
  output logic             sb_err,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, JB_WAIT, FLUSH} state_t;
  localparam logic [7:0] TO_MAX = 8'(JB_TIMEOUT);
  state_t             state_q, state_d;
  logic [15:0]        pending_q, pending_d;
  logic [7:0]         to_q, to_d;
  logic               jb_err_q, jb_err_d, sb_err_q, sb_err_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               hazard, set_wr;
  always_comb begin
    hazard = (if_rs1_used & pending_q[if_rs1]) | (if_rs2_used & pending_q[if_rs2])
           | (if_rd_wr & pending_q[if_rd]);
    // rst_n gating keeps the handshake quiet while reset is held
    issue = rst_n & (state_q == RUN) & if_valid & !hazard & !mem_busy;
    pc_en = rst_n & (((state_q == RUN) & !mem_busy & (issue | !if_valid)) | (state_q == FLUSH));
    flush_if = rst_n & (state_q == FLUSH);
    dec_bubble = !issue;
    set_wr = issue & if_rd_wr;
    pending_d = pending_q;
    if (wb_wrt_en) pending_d[wb_wrt_reg] = 1'b0;
    if (set_wr) pending_d[if_rd] = 1'b1;
    // a retire coinciding with a new write to the same register is legal
    sb_err_d = sb_err_q | (wb_wrt_en & !pending_q[wb_wrt_reg] & !(set_wr & (if_rd == wb_wrt_reg)));
    stall_d = (if_valid & !issue & ~&stall_q) ? stall_q + 1'b1 : stall_q;
    state_d = state_q;
    to_d = to_q;
    jb_err_d = jb_err_q;
    case (state_q)
      RUN: if (issue & if_is_jb) begin
        state_d = JB_WAIT;
        to_d = '0;
      end
      JB_WAIT: if (jb_resolve) state_d = jb_taken ? FLUSH : RUN;
      else if (to_q == TO_MAX) begin
        state_d = RUN;
        jb_err_d = 1'b1;
      end else if (!mem_busy) to_d = to_q + 8'd1;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pending_q <= '0;
      to_q <= '0;
      jb_err_q <= 1'b0;
      sb_err_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      to_q <= to_d;
      jb_err_q <= jb_err_d;
      sb_err_q <= sb_err_d;
      stall_q <= stall_d;
    end
  end
  assign pending = pending_q;
  assign jb_err = jb_err_q;
  assign sb_err = sb_err_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// tb_cpu_pipe_ctrl: table-driven directed checks of cpu_pipe_ctrl plus
// hand-written timeout, saturation and reset sequences.
module tb_cpu_pipe_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_valid, if_rs1_used, if_rs2_used, if_rd_wr, if_is_jb, wb_wrt_en, mem_busy, jb_resolve, jb_taken;
  logic [3:0] if_rs1, if_rs2, if_rd, wb_wrt_reg;
  logic issue, pc_en, dec_bubble, flush_if, jb_err, sb_err;
  logic [15:0] pending;
  logic [3:0] stall_cnt;
  int checks = 0, failures = 0;

  cpu_pipe_ctrl #(.JB_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_rs1(if_rs1), .if_rs2(if_rs2),
    .if_rs1_used(if_rs1_used), .if_rs2_used(if_rs2_used), .if_rd(if_rd), .if_rd_wr(if_rd_wr),
    .if_is_jb(if_is_jb), .wb_wrt_en(wb_wrt_en), .wb_wrt_reg(wb_wrt_reg), .mem_busy(mem_busy),
    .jb_resolve(jb_resolve), .jb_taken(jb_taken), .issue(issue), .pc_en(pc_en),
    .dec_bubble(dec_bubble), .flush_if(flush_if), .pending(pending), .jb_err(jb_err),
    .sb_err(sb_err), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic v, u1; logic [3:0] rs1; logic u2; logic [3:0] rs2; logic rdw; logic [3:0] rd;
    logic jb, wbe; logic [3:0] wbr; logic mb, res, tk;
    logic e_iss, e_pc, e_fl; logic [15:0] e_pend; logic [3:0] e_st; logic e_sb, e_jb;
  } vec_t;
  vec_t vec [26];

  task automatic drive(input logic v, input logic u1, input logic [3:0] rs1, input logic u2,
                       input logic [3:0] rs2, input logic rdw, input logic [3:0] rd, input logic jb,
                       input logic wbe, input logic [3:0] wbr, input logic mb, input logic res,
                       input logic tk);
    if_valid = v; if_rs1_used = u1; if_rs1 = rs1; if_rs2_used = u2; if_rs2 = rs2;
    if_rd_wr = rdw; if_rd = rd; if_is_jb = jb; wb_wrt_en = wbe; wb_wrt_reg = wbr;
    mem_busy = mb; jb_resolve = res; jb_taken = tk;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {6'd0, issue, pc_en, dec_bubble, flush_if, pending, stall_cnt, sb_err, jb_err};
  endfunction

  function automatic logic [31:0] exp_outs(input logic iss, input logic pc, input logic fl,
                                           input logic [15:0] pd, input logic [3:0] st,
                                           input logic sb, input logic jb);
    return {6'd0, iss, pc, !iss, fl, pd, st, sb, jb};
  endfunction

  initial begin
    //          v u1 rs1 u2 rs2 rdw rd jb wbe wbr mb res tk | iss pc fl pend st sb jb
    vec[0]  = '{1,1,1,1,2,1,3,0,0,0,0,0,0, 1,1,0,16'h0000,0,0,0};
    vec[1]  = '{1,1,3,1,1,1,4,0,0,0,0,0,0, 0,0,0,16'h0008,0,0,0};
    vec[2]  = '{1,1,3,1,1,1,4,0,0,0,0,0,0, 0,0,0,16'h0008,1,0,0};
    vec[3]  = '{1,1,3,1,1,1,4,0,1,3,0,0,0, 0,0,0,16'h0008,2,0,0};
    vec[4]  = '{1,1,3,1,1,1,4,0,0,0,0,0,0, 1,1,0,16'h0000,3,0,0};
    vec[5]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,16'h0010,3,0,0};
    vec[6]  = '{0,0,0,0,0,0,0,0,1,4,0,0,0, 0,1,0,16'h0010,3,0,0};
    vec[7]  = '{1,0,0,0,0,1,5,0,1,5,0,0,0, 1,1,0,16'h0000,3,0,0};
    vec[8]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,16'h0020,3,0,0};
    vec[9]  = '{0,0,0,0,0,0,0,0,1,5,0,0,0, 0,1,0,16'h0020,3,0,0};
    vec[10] = '{1,0,0,0,0,0,0,1,0,0,0,0,0, 1,1,0,16'h0000,3,0,0};
    vec[11] = '{1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,3,0,0};
    vec[12] = '{1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,4,0,0};
    vec[13] = '{1,0,0,0,0,0,0,0,0,0,0,1,1, 0,0,0,16'h0000,5,0,0};
    vec[14] = '{1,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,1,16'h0000,6,0,0};
    vec[15] = '{1,0,0,0,0,0,0,0,0,0,0,0,0, 1,1,0,16'h0000,7,0,0};
    vec[16] = '{1,0,0,0,0,0,0,1,0,0,0,0,0, 1,1,0,16'h0000,7,0,0};
    vec[17] = '{0,0,0,0,0,0,0,0,0,0,0,1,0, 0,0,0,16'h0000,7,0,0};
    vec[18] = '{1,0,0,0,0,0,0,0,0,0,0,1,1, 1,1,0,16'h0000,7,0,0};
    vec[19] = '{1,0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,16'h0000,7,0,0};
    vec[20] = '{1,0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,16'h0000,8,0,0};
    vec[21] = '{1,0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,16'h0000,9,0,0};
    vec[22] = '{1,0,0,0,0,0,0,0,0,0,0,0,0, 1,1,0,16'h0000,10,0,0};
    vec[23] = '{0,0,0,0,0,0,0,0,1,9,0,0,0, 0,1,0,16'h0000,10,0,0};
    vec[24] = '{0,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,16'h0000,10,1,0};
    vec[25] = '{0,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,16'h0000,10,1,0};

    drive(1,0,0,0,0,0,0,0,0,0,0,0,0);
    #2 chk("reset_outputs", outs(), exp_outs(0,0,0,16'h0,4'd0,0,0));
    @(negedge clk) rst_n = 1'b1;

    foreach (vec[i]) begin
      @(negedge clk);
      drive(vec[i].v, vec[i].u1, vec[i].rs1, vec[i].u2, vec[i].rs2, vec[i].rdw, vec[i].rd,
            vec[i].jb, vec[i].wbe, vec[i].wbr, vec[i].mb, vec[i].res, vec[i].tk);
      #1 chk($sformatf("vec%0d", i), outs(),
             exp_outs(vec[i].e_iss, vec[i].e_pc, vec[i].e_fl, vec[i].e_pend, vec[i].e_st,
                      vec[i].e_sb, vec[i].e_jb));
    end

    // stall counter saturates at all-ones (10 + 8 would wrap to 2)
    for (int k = 0; k < 8; k++) begin
      @(negedge clk) drive(1,0,0,0,0,0,0,0,0,0,1,0,0);
    end
    @(negedge clk) drive(0,0,0,0,0,0,0,0,0,0,0,0,0);
    #1 chk("stall_saturate", 32'(stall_cnt), 32'd15);

    // timeout: 5 JB_WAIT cycles with JB_TIMEOUT=4, then RUN with jb_err
    @(negedge clk) drive(1,0,0,0,0,0,0,1,0,0,0,0,0);
    #1 chk("to_issue_jb", 32'(issue), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) drive(0,0,0,0,0,0,0,0,0,0,0,0,0);
      #1 chk($sformatf("to_wait%0d", k), {30'd0, pc_en, jb_err}, 32'd0);
    end
    @(negedge clk) drive(0,0,0,0,0,0,0,0,0,0,0,1,1);
    #1 chk("to_exit", {30'd0, pc_en, jb_err}, 32'd3);
    @(negedge clk) drive(0,0,0,0,0,0,0,0,0,0,0,0,0);
    #1 chk("late_resolve_ignored", {30'd0, pc_en, flush_if}, 32'd2);

    // reset mid-JB_WAIT with a pending write
    @(negedge clk) drive(1,0,0,0,0,1,7,1,0,0,0,0,0);
    #1 chk("rst_seq_issue", 32'(issue), 32'd1);
    @(negedge clk) drive(1,0,0,0,0,0,0,0,0,0,0,0,0);
    #1 chk("rst_seq_wait", {15'd0, issue, pending}, 32'h0080);
    #1 rst_n = 1'b0;
    #1 chk("rst_async", outs(), exp_outs(0,0,0,16'h0,4'd0,0,0));
    @(negedge clk) rst_n = 1'b1;
    #1 chk("after_reset_issue", {15'd0, issue, pending}, 32'h10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
